// File: rtl/spi_flash_reader.sv
// SPI mode-0 master reading a byte block from serial flash onto a valid/ready stream.
// Build option SPI_FAST_READ_EN: issue FAST READ (0x0B) with one dummy byte instead of READ (0x03).
module spi_flash_reader #(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 16
) (
  input  logic             clk125m,
  input  logic             rst_n,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [7:0]       dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             cs_n,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
);
  // state    | meaning
  // IDLE     | bus idle, waiting for start
  // CS_SETUP | cs_n low, command MSB on mosi, before first SCK
  // CMD      | shifting the 8-bit command
  // ADDR     | shifting the 24-bit address
  // DUMMY    | fast-read dummy byte, mosi low, nothing captured
  // DATA     | shifting in data bytes, may stall between bytes
  // CS_HOLD  | sclk low after last bit, then release cs_n
  // DRAIN    | wait for the consumer to take the last byte
  // GAP      | minimum cs_n high time, start ignored
`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
  localparam logic [7:0] CMD_BYTE = 8'h03;
`endif
  localparam int DIV_W = $clog2(2*CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LOAD = DIV_W'(2*CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, CS_SETUP, CMD, ADDR, DUMMY, DATA, CS_HOLD, DRAIN, GAP
  } state_t;

  state_t           r_state,     w_state;
  logic [DIV_W-1:0] r_div,       w_div;
  logic [4:0]       r_bit_cnt,   w_bit_cnt;
  logic             r_sclk,      w_sclk;
  logic             r_cs_n,      w_cs_n;
  logic [31:0]      r_shift_out, w_shift_out;
  logic [7:0]       r_shift_in,  w_shift_in;
  logic [LEN_W-1:0] r_remain,    w_remain;
  logic [7:0]       r_dout,      w_dout;
  logic             r_dout_valid, w_dout_valid;
  logic             r_busy,      w_busy;
  logic             r_done,      w_done;
  logic             w_stall;

  always_ff @(posedge clk125m or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_div        <= '0;
      r_bit_cnt    <= '0;
      r_sclk       <= 1'b0;
      r_cs_n       <= 1'b1;
      r_shift_out  <= '0;
      r_shift_in   <= '0;
      r_remain     <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_div        <= w_div;
      r_bit_cnt    <= w_bit_cnt;
      r_sclk       <= w_sclk;
      r_cs_n       <= w_cs_n;
      r_shift_out  <= w_shift_out;
      r_shift_in   <= w_shift_in;
      r_remain     <= w_remain;
      r_dout       <= w_dout;
      r_dout_valid <= w_dout_valid;
      r_busy       <= w_busy;
      r_done       <= w_done;
    end
  end

  // Hold SCK low before a byte's first rise while the previous byte is still unconsumed.
  assign w_stall = (r_state == DATA) && (r_bit_cnt == 5'd7) && r_dout_valid && !dout_ready;

  always_comb begin
    w_state      = r_state;
    w_div        = r_div;
    w_bit_cnt    = r_bit_cnt;
    w_sclk       = r_sclk;
    w_cs_n       = r_cs_n;
    w_shift_out  = r_shift_out;
    w_shift_in   = r_shift_in;
    w_remain     = r_remain;
    w_dout       = r_dout;
    w_dout_valid = r_dout_valid;
    w_busy       = r_busy;
    w_done       = 1'b0;

    if (r_dout_valid && dout_ready) w_dout_valid = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            w_done = 1'b1;
          end else begin
            w_state     = CS_SETUP;
            w_cs_n      = 1'b0;
            w_busy      = 1'b1;
            w_div       = DIV_LOAD;
            w_shift_out = {CMD_BYTE, addr};
            w_remain    = len;
          end
        end
      end
      CS_SETUP: begin
        if (r_div != '0) begin
          w_div = r_div - 1'b1;
        end else begin
          w_state   = CMD;
          w_div     = DIV_LOAD;
          w_bit_cnt = 5'd7;
        end
      end
      CMD, ADDR, DUMMY, DATA: begin
        // Byte completes on the first cycle of the 8th high phase; a new byte overrides a handshake.
        if ((r_state == DATA) && r_sclk && (r_bit_cnt == '0) && (r_div == DIV_LOAD)) begin
          w_dout       = r_shift_in;
          w_dout_valid = 1'b1;
          w_remain     = r_remain - 1'b1;
        end
        if (r_div != '0) begin
          w_div = r_div - 1'b1;
        end else if (!r_sclk) begin
          if (!w_stall) begin
            w_sclk     = 1'b1;
            w_div      = DIV_LOAD;
            w_shift_in = {r_shift_in[6:0], miso};
          end
        end else begin
          w_sclk      = 1'b0;
          w_div       = DIV_LOAD;
          w_shift_out = {r_shift_out[30:0], 1'b0};
          if (r_bit_cnt != '0) begin
            w_bit_cnt = r_bit_cnt - 1'b1;
          end else begin
            w_bit_cnt = 5'd7;
            if (r_state == CMD) begin
              w_state   = ADDR;
              w_bit_cnt = 5'd23;
            end else if (r_state == ADDR) begin
`ifdef SPI_FAST_READ_EN
              w_state = DUMMY;
`else
              w_state = DATA;
`endif
            end else if (r_state == DUMMY) begin
              w_state = DATA;
            end else if (w_remain == '0) begin
              w_state = CS_HOLD;
            end
          end
        end
      end
      CS_HOLD: begin
        if (r_div != '0) begin
          w_div = r_div - 1'b1;
        end else begin
          w_cs_n  = 1'b1;
          w_state = DRAIN;
        end
      end
      DRAIN: begin
        if (!r_dout_valid) begin
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_state = GAP;
          w_div   = GAP_LOAD;
        end
      end
      GAP: begin
        if (r_div != '0) w_div = r_div - 1'b1;
        else             w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign cs_n       = r_cs_n;
  assign sclk       = r_sclk;
  assign mosi       = r_shift_out[31];

endmodule

// File: tb/tb_spi_flash_reader.sv
// Scoreboard bench for spi_flash_reader with a behavioural mode-0 flash responder.
module tb_spi_flash_reader;
`ifdef SPI_FAST_READ_EN
  localparam int HDR = 40;
`else
  localparam int HDR = 32;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, dout_valid, cs_n, sclk, mosi;
  logic [7:0]  dout;
  logic        dout_ready = 1'b1;
  logic        miso = 1'b0;

  int total = 0;
  int bad = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  flash_data [8];
  logic [63:0] hdr_bits = '0;
  int          bit_idx = 0;
  int          sck_total = 0;
  int          cs_falls = 0;
  int          done_cnt = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_cs_n = 1'b1;

  spi_flash_reader dut (
    .clk125m(clk), .rst_n(rst_n), .start(start), .addr(addr), .len(len),
    .busy(busy), .done(done), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flash responder: shifts data out after the header, changing miso after SCK falls.
  always @(negedge clk) begin
    logic [7:0] b;
    int k;
    if (!cs_n && prev_cs_n) cs_falls++;
    if (cs_n) begin
      bit_idx = 0;
      miso = 1'b0;
    end else if (sclk && !prev_sclk) begin
      if (bit_idx < HDR) hdr_bits = {hdr_bits[62:0], mosi};
      bit_idx++;
      sck_total++;
    end else if (!sclk && prev_sclk && bit_idx >= HDR) begin
      k = bit_idx - HDR;
      b = flash_data[(k / 8) % 8];
      miso = b[7 - (k % 8)];
    end
    prev_sclk = sclk;
    prev_cs_n = cs_n;
  end

  // Output monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got %0h expected none", dout);
      end else begin
        check("dout_byte", dout, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [23:0] a, input logic [15:0] l);
    addr = a;
    len = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n = 0;
    while (!done && n < max_cycles) begin
      tick();
      n++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic load_flash(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    flash_data[0] = b0; flash_data[1] = b1; flash_data[2] = b2; flash_data[3] = b3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s_sck, s_done, s_cs, viol_sck, viol_valid, n;
    for (int i = 0; i < 8; i++) flash_data[i] = 8'h00;

    repeat (3) tick();
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_dout", dout, 8'h00);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic read, ready high throughout.
    load_flash(8'hA5, 8'h5A, 8'h01, 8'hFE);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    exp_q.push_back(8'h01); exp_q.push_back(8'hFE);
    s_sck = sck_total; s_done = done_cnt;
    do_start(24'h000100, 16'd4);
    check("start_cs_low", cs_n, 0);
    check("start_busy", busy, 1);
    repeat (3) tick();
    check("pre_first_rise_sclk", sclk, 0);
    tick();
    check("first_rise_sclk", sclk, 1);
    wait_done(2000);
    repeat (4) tick();
`ifdef SPI_FAST_READ_EN
    check("basic_hdr", hdr_bits[HDR-1:0], 40'h0B00010000);
    check("basic_rises", sck_total - s_sck, 72);
`else
    check("basic_hdr", hdr_bits[HDR-1:0], 32'h03000100);
    check("basic_rises", sck_total - s_sck, 64);
`endif
    check("basic_done_cnt", done_cnt - s_done, 1);
    check("basic_cs_high", cs_n, 1);
    check("basic_busy_low", busy, 0);
    check("basic_q_empty", exp_q.size(), 0);

    // Backpressure: consumer stalls for 100 cycles after the first byte.
    load_flash(8'h3C, 8'hC3, 8'h81, 8'h00);
    exp_q.push_back(8'h3C); exp_q.push_back(8'hC3); exp_q.push_back(8'h81);
    do_start(24'h000200, 16'd3);
    n = 0;
    while (!dout_valid && n < 1000) begin tick(); n++; end
    check("bp_first_valid", dout_valid, 1);
    tick();
    dout_ready = 1'b0;
    viol_sck = 0; viol_valid = 0; s_sck = sck_total;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i == 50) s_sck = sck_total;
      if (i >= 50) begin
        if (sclk !== 1'b0 || cs_n !== 1'b0) viol_sck++;
        if (dout_valid !== 1'b1) viol_valid++;
      end
    end
    check("bp_stall_sclk_cs", viol_sck, 0);
    check("bp_stall_valid_held", viol_valid, 0);
    check("bp_stall_no_rises", sck_total - s_sck, 0);
    dout_ready = 1'b1;
    wait_done(2000);
    repeat (4) tick();
    check("bp_q_empty", exp_q.size(), 0);

    // Zero length.
    s_cs = cs_falls; s_done = done_cnt;
    do_start(24'h000300, 16'd0);
    check("zl_done", done, 1);
    check("zl_busy", busy, 0);
    check("zl_cs_n", cs_n, 1);
    tick();
    check("zl_done_cleared", done, 0);
    repeat (10) tick();
    check("zl_no_cs_fall", cs_falls - s_cs, 0);
    check("zl_done_cnt", done_cnt - s_done, 1);

    // Start while busy, second request arrives mid-address.
    load_flash(8'h11, 8'h22, 8'h00, 8'h00);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    s_sck = sck_total; s_done = done_cnt;
    do_start(24'h123456, 16'd2);
    n = 0;
    while (bit_idx < 12 && n < 1000) begin tick(); n++; end
    do_start(24'hABCDEF, 16'd5);
    wait_done(2000);
    repeat (30) tick();
`ifdef SPI_FAST_READ_EN
    check("sb_hdr", hdr_bits[HDR-1:0], 40'h0B12345600);
    check("sb_rises", sck_total - s_sck, 56);
`else
    check("sb_hdr", hdr_bits[HDR-1:0], 32'h03123456);
    check("sb_rises", sck_total - s_sck, 48);
`endif
    check("sb_done_cnt", done_cnt - s_done, 1);
    check("sb_cs_high", cs_n, 1);
    check("sb_q_empty", exp_q.size(), 0);

    // Reset during the second data byte, then a one-byte read.
    load_flash(8'h77, 8'h88, 8'h99, 8'h00);
    exp_q.push_back(8'h77); exp_q.push_back(8'h88); exp_q.push_back(8'h99);
    do_start(24'h000400, 16'd3);
    n = 0;
    while (bit_idx < HDR + 11 && n < 1000) begin tick(); n++; end
    rst_n = 1'b0;
    #1;
    check("mr_cs_n", cs_n, 1);
    check("mr_sclk", sclk, 0);
    check("mr_mosi", mosi, 0);
    check("mr_dout_valid", dout_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    load_flash(8'h42, 8'h00, 8'h00, 8'h00);
    exp_q.push_back(8'h42);
    s_done = done_cnt;
    do_start(24'h000010, 16'd1);
    wait_done(2000);
    repeat (4) tick();
    check("mr_after_done_cnt", done_cnt - s_done, 1);
    check("mr_after_q_empty", exp_q.size(), 0);

`ifdef SPI_FAST_READ_EN
    load_flash(8'hC0, 8'h3F, 8'h00, 8'h00);
    exp_q.push_back(8'hC0); exp_q.push_back(8'h3F);
    s_sck = sck_total;
    do_start(24'h0000FF, 16'd2);
    wait_done(2000);
    repeat (4) tick();
    check("fr_hdr", hdr_bits[HDR-1:0], 40'h0B0000FF00);
    check("fr_rises", sck_total - s_sck, 56);
    check("fr_q_empty", exp_q.size(), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

SPI mode-0 master that reads a block of bytes from the board's serial configuration flash (`flash_cs_n`/`flash_sclk`/`flash_mosi`/`flash_miso`) and streams them out on a valid/ready byte interface.
- It is the initiator-side counterpart to the SPI EEPROM responder already in the design.
- It issues READ (0x03) with a 24-bit address, then clocks in `len` bytes.
- It applies backpressure by pausing SCK between bytes.
- It sits in `top` between the flash pins and the NIC-initialisation logic that consumes NVM contents.

## Interface
Parameters:
- `CLK_DIV`, 2: SCK half-period in `clk125m` cycles; must be ≥1. Default gives SCK = 31.25 MHz.
- `LEN_W`, 16: width of the byte-count input.

Ports:
- `clk125m` input 1: sole clock. One clock domain; reset is asynchronous and active-low.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request. Sampled only while `busy`=0.
- `addr` input 24: flash byte address. Captured on `start`.
- `len` input LEN_W: number of bytes to read. Captured on `start`.
- `busy` output 1: high from the accepted `start` until `done`.
- `done` output 1: one-cycle pulse at the end of the transfer.
- `dout` output 8: read byte, MSB received first.
- `dout_valid` output 1: `dout` holds an unconsumed byte.
- `dout_ready` input 1: consumer accepts `dout` when `dout_valid`&`dout_ready`.
- `cs_n` output 1: flash chip select.
- `sclk` output 1: SPI clock, idles low.
- `mosi` output 1: serial command/address out.
- `miso` input 1: serial data in.

## Operation
- States: IDLE → CS_SETUP → CMD → ADDR → DATA → CS_HOLD → DRAIN → GAP → IDLE.
- **IDLE**
  - `cs_n`=1, `sclk`=0.
  - On `start` with `len`≠0: latch `addr`/`len`, raise `busy`, drive `cs_n`=0, go to CS_SETUP.
  - On `start` with `len`=0: no SPI activity and `busy` stays 0. `done` pulses on the next cycle.
- **CS_SETUP**: hold for CLK_DIV cycles, with MSB of the command on `mosi`.
- **Bit timing**
  - Each bit is one low half-period followed by one high half-period, each CLK_DIV cycles.
  - `mosi` changes only while `sclk` is low.
  - `miso` is sampled on the `clk125m` edge where `sclk` rises.
- **CMD**: 8 bits of 0x03, MSB first.
- **ADDR**: 24 bits of the latched address, MSB first. `mosi` is held 0 after the last address bit.
- **DATA**
  - Shift 8 bits per byte, decrementing the remaining count.
  - At the byte boundary the shifted byte moves to the `dout` register and `dout_valid` is set.
  - **Stall**: before starting the next byte's first rising edge, if `dout_valid`=1 and `dout_ready`=0, hold `sclk` low and wait. `cs_n` stays 0.
- **Simultaneous transfer**: consumer handshake and new-byte load in the same cycle → the new byte wins and `dout_valid` stays 1.
- **CS_HOLD**: after the last byte's final high half-period, drive `sclk` low for CLK_DIV cycles, then `cs_n`=1.
- **DRAIN**: wait until `dout_valid`=0, then pulse `done` and drop `busy`.
- **GAP**: `cs_n` stays high for 2×CLK_DIV cycles before IDLE. `start` is ignored here.
- **Start while busy**: `start` asserted while `busy`=1 or in GAP is ignored and not queued.
- **Flash-side wrap**: address wrap past 0xFFFFFF is left to the flash. The block only counts bytes.
- **Reset**: asserting `rst_n` mid-transfer immediately forces `cs_n`=1, `sclk`=0, `mosi`=0, `dout_valid`=0, `busy`=0, `done`=0, state=IDLE. A partial byte is discarded.

## Timing
- **Reset values**: `cs_n`=1, `sclk`=0, `mosi`=0, `dout`=0x00, `dout_valid`=0, `busy`=0, `done`=0.
- **Start to chip select**: `start` at cycle 0 → `cs_n` low and `busy` high at cycle 1.
- **First SCK rise**: cycle 1+2·CLK_DIV (CLK_DIV setup cycles, then the CLK_DIV-cycle low phase of bit 0).
- **Bit period**: 2·CLK_DIV cycles.
- **Command/address phase**: 32 bits, 64·CLK_DIV cycles.
- **Unstalled data**: `dout_valid` rises 1 cycle after the 8th rising edge of each data byte. Bytes arrive every 16·CLK_DIV cycles.
- **Minimum transfer** (never stalled): `done` follows `cs_n` rising by 1 cycle when `dout_valid` is already clear.
- **Outputs**: all outputs are registered.

## Configuration
- `SPI_FAST_READ_EN` defined:
  - Command is 0x0B (FAST READ).
  - One dummy byte of 8 SCK cycles with `mosi`=0 follows the address.
  - The dummy byte is not presented on `dout`.
  - First `dout_valid` is delayed by 16·CLK_DIV cycles.
- Undefined: command is 0x03 and there is no dummy phase.

## Test plan
- **Basic read**: `addr`=0x000100, `len`=4, flash model holds 0xA5,0x5A,0x01,0xFE; `dout_ready` tied high.
  - `mosi` bits = 0x03,0x00,0x01,0x00.
  - `dout` sequence A5,5A,01,FE.
  - Exactly 64 SCK rises; one `done` pulse; `cs_n` high afterwards.
- **Backpressure**: `len`=3, `dout_ready` low for 100 cycles after the first byte.
  - `sclk` stays low with `cs_n`=0 during the stall.
  - No byte is lost or duplicated; all three bytes arrive in order.
- **Zero length**: `len`=0.
  - `cs_n` never falls.
  - `done` pulses at cycle 1; `busy` stays 0.
- **Start while busy**: second `start` (different `addr`) mid-ADDR.
  - Ignored: the first transfer completes unchanged and only one `done` pulses.
- **Mid-transfer reset**: `rst_n` asserted during DATA byte 2, then deasserted.
  - All outputs hold reset values immediately.
  - A subsequent `start` with `len`=1 completes normally.
- **SPI_FAST_READ_EN**: `addr`=0x0000FF, `len`=2.
  - `mosi` bits = 0x0B,0x00,0x00,0xFF,0x00.
  - 2 bytes delivered; 56 SCK rises total.
